seq_mul16: RTL and testbench

//  Sequential shift-add multiplier: the stage between the 16-bit operand registers
//  and the 32-bit result register. It takes two WIDTH-bit operands, produces a 2*WIDTH-bit product

---
 rtl/mul_pkg.sv | 6 +
 rtl/seq_mul16_dp.sv | 84 ++++++++
 rtl/seq_mul16.sv | 72 +++++++
 tb/tb_seq_mul16.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam int MUL_WIDTH = 16;
  localparam int CNT_W     = $clog2(MUL_WIDTH);
endpackage

// File: rtl/seq_mul16_dp.sv
// Multiplier datapath: operand magnitudes, accumulator shift pair, sign flag,
// iteration counter and the final conditional negate into the product register.
module seq_mul16_dp
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 last_i,
  input  logic                 is_signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [CW-1:0]        cnt_o,
  output logic [2*WIDTH-1:0]   product_o
);

  logic [WIDTH-1:0]   mag_a_q, mag_a_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;

  logic [WIDTH-1:0]   a_abs, b_abs, addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  always_comb begin
    // The most-negative operand negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
    a_abs    = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_abs    = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    addend   = mag_b_q[0] ? mag_a_q : '0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_step = {sum, acc_q[WIDTH-1:1]};

    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (load_i) begin
      mag_a_d = a_abs;
      mag_b_d = b_abs;
      neg_d   = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      acc_d   = '0;
      cnt_d   = '0;
    end else if (step_i) begin
      acc_d   = acc_step;
      mag_b_d = mag_b_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      if (last_i) begin
        product_d = neg_q ? -acc_step : acc_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign product_o = product_q;

endmodule

// File: rtl/seq_mul16.sv
// Sequential shift-add multiplier, WIDTH cycles per operation, unsigned or signed.
// state | meaning: IDLE = waiting for start | RUN = one shift-add per edge | DONE = product valid, ld pulse
module seq_mul16
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic                 prod_ld,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  mul_state_t    state_q, state_d;
  logic          load, step, last;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH-1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign prod_ld = done;

  seq_mul16_dp #(.WIDTH(WIDTH), .CW(CW)) u_dp (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .step_i      (step),
    .last_i      (last),
    .is_signed_i (is_signed),
    .a_i         (a),
    .b_i         (b),
    .cnt_o       (cnt),
    .product_o   (product)
  );

endmodule

// File: tb/tb_seq_mul16.sv
// Self-checking bench for seq_mul16 against an integer-arithmetic reference model.
module tb_seq_mul16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [15:0] a, b;
  logic        busy, done, prod_ld;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  seq_mul16 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .prod_ld   (prod_ld),
    .product   (product)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    longint vx, vy;
    vx = longint'(x);
    vy = longint'(y);
    if (s && x[15]) vx = vx - 65536;
    if (s && y[15]) vy = vy - 65536;
    return 32'(vx * vy);
  endfunction

  // Caller is #1 after an edge with the DUT idle; returns #1 after the edge following done.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        input string name);
    int n;
    logic [31:0] exp;
    exp = ref_mul(ta, tb_, ts);
    a = ta; b = tb_; is_signed = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, expected 16", name, n);
    end
    checks++;
    if (product !== exp) begin
      errors++;
      $display("FAIL %s product: got %h, expected %h", name, product, exp);
    end
    checks++;
    if (prod_ld !== done) begin
      errors++;
      $display("FAIL %s prod_ld: got %b, expected %b", name, prod_ld, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== exp) begin
      errors++;
      $display("FAIL %s after-done: busy=%b done=%b product=%h, expected 0 0 %h",
               name, busy, done, product, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || prod_ld !== 1'b0 || product !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b prod_ld=%b product=%h, expected all 0",
               busy, done, prod_ld, product);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_op(16'd3, 16'd5, 1'b0, "basic_3x5");
    checks++;
    if (product !== 32'd15) begin
      errors++;
      $display("FAIL basic_const: got %h, expected 0000000f", product);
    end
  endtask

  task automatic test_corners();
    run_op(16'hFFFF, 16'hFFFF, 1'b0, "unsigned_ffff");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, "signed_m1_m1");
    run_op(16'h8000, 16'h8000, 1'b1, "signed_min_min");
    run_op(16'h8000, 16'h0001, 1'b1, "signed_min_1");
    run_op(16'hFFF9, 16'h0006, 1'b1, "signed_m7_6");
    run_op(16'h0000, 16'hFFFF, 1'b1, "zero_operand");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [31:0] exp, got;
    exp = ref_mul(16'h1234, 16'h00FF, 1'b0);
    got = '0;
    dones = 0;
    a = 16'h1234; b = 16'h00FF; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        dones++;
        got = product;
      end
      start = 1'b0;
      if (i == 3 || i == 10) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_start dones: got %0d, expected 1", dones);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ignore_start product: got %h, expected %h", got, exp);
    end
  endtask

  task automatic test_mid_reset();
    a = 16'h1234; b = 16'h5678; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || prod_ld !== 1'b0 || product !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b prod_ld=%b product=%h, expected all 0",
               busy, done, prod_ld, product);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset hold: done=%b busy=%b, expected 0 0", done, busy);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 32'd0) begin
        errors++;
        $display("FAIL post_reset: done=%b busy=%b product=%h, expected 0 0 0",
                 done, busy, product);
      end
    end
    run_op(16'd2, 16'd9, 1'b0, "after_reset_2x9");
  endtask

  task automatic test_back_to_back();
    int last_done, ndone, n;
    last_done = -1;
    ndone = 0;
    a = 16'd0; b = 16'd1234; is_signed = 1'b0; start = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      checks++;
      if (prod_ld !== done) begin
        errors++;
        $display("FAIL b2b prod_ld: got %b, expected %b at cycle %0d", prod_ld, done, i);
      end
      if (done === 1'b1) begin
        checks++;
        if (product !== 32'd0) begin
          errors++;
          $display("FAIL b2b product: got %h, expected 00000000", product);
        end
        if (last_done >= 0) begin
          checks++;
          if (i - last_done != 18) begin
            errors++;
            $display("FAIL b2b period: got %0d, expected 18", i - last_done);
          end
        end
        last_done = i;
        ndone++;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone != 4) begin
      errors++;
      $display("FAIL b2b count: got %0d dones, expected 4", ndone);
    end
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b drain: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
